// File: rtl/input_ctrl_pkg.sv
// Shared types and default opcodes for the operand sequencer.
package input_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, ISSUE} state_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_SQRT_NEG, ERR_DIV_ZERO, ERR_TIMEOUT} err_code_t;

  localparam logic [1:0] DIV_OPCODE_DEFAULT  = 2'b00;
  localparam logic [1:0] SQRT_OPCODE_DEFAULT = 2'b01;

endpackage

// File: rtl/sign_mag_converter.sv
// Two's-complement to sign-magnitude; the most negative value maps to mag 2^(WL-1).
module sign_mag_converter #(
  parameter int unsigned WORD_LENGTH = 8
) (
  input  logic [WORD_LENGTH-1:0] data,
  output logic [WORD_LENGTH-1:0] mag,
  output logic                   sign
);

  assign sign = data[WORD_LENGTH-1];
  assign mag  = sign ? WORD_LENGTH'(-data) : data;

endmodule

// File: rtl/operand_sequencer.sv
// Operand-entry controller: opcode capture, operand collection, legality check and
// valid/ready start handshake towards the arithmetic datapath.
module operand_sequencer
  import input_ctrl_pkg::*;
#(
  parameter int unsigned WORD_LENGTH    = 8,
  parameter int unsigned NUM_OPERANDS   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [1:0]  DIV_OPCODE     = DIV_OPCODE_DEFAULT,
  parameter logic [1:0]  SQRT_OPCODE    = SQRT_OPCODE_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WORD_LENGTH-1:0]              data,
  input  logic [1:0]                          opCode,
  input  logic                                start,
  input  logic                                load,
  input  logic                                abort,
  input  logic                                ready_in,
  output logic [NUM_OPERANDS*WORD_LENGTH-1:0] operands_out,
  output logic [NUM_OPERANDS-1:0]             signs_out,
  output logic [1:0]                          opCode_R_out,
  output logic [NUM_OPERANDS-1:0]             load_mask_out,
  output logic                                start_out,
  output logic                                busy,
  output logic                                error,
  output logic [1:0]                          error_code
);

  localparam int unsigned IDX_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPERANDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                  state_q, state_d;
  err_code_t               err_q, err_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [1:0]              opcode_q, opcode_d;
  logic                    start_q, load_q;
  logic                    start_edge, load_edge;
  logic [WORD_LENGTH-1:0]  conv_mag;
  logic                    conv_sign;
  logic                    div_zero;
  logic [NUM_OPERANDS-1:0] mask_c;

  sign_mag_converter #(.WORD_LENGTH(WORD_LENGTH)) u_conv (
    .data (data),
    .mag  (conv_mag),
    .sign (conv_sign)
  );

  assign start_edge    = start & ~start_q;
  assign load_edge     = load & ~load_q;
  assign load_mask_out = mask_c;
  assign opCode_R_out  = opcode_q;
  assign error_code    = err_q;

  // Divide-by-zero only exists when there is a divisor slot
  if (NUM_OPERANDS >= 2) begin : g_div
    assign div_zero = (operands_out[WORD_LENGTH +: WORD_LENGTH] == '0);
  end else begin : g_no_div
    assign div_zero = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    idx_d    = idx_q;
    last_d   = last_q;
    timer_d  = timer_q;
    opcode_d = opcode_q;
    mask_c   = '0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            opcode_d = opCode;
            err_d    = ERR_NONE;
            last_d   = (opCode == SQRT_OPCODE) ? '0 : IDX_LAST;
            idx_d    = '0;
            timer_d  = '0;
            state_d  = LOAD;
          end
        end
        LOAD: begin
          if (load_edge) begin
            for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
              if (idx_q == IDX_W'(k)) mask_c[k] = 1'b1;
            end
            timer_d = '0;
            if (idx_q == last_q) state_d = CHECK;
            else                 idx_d   = idx_q + 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
            if ((TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST)) begin
              state_d = IDLE;
              err_d   = ERR_TIMEOUT;
            end
          end
        end
        CHECK: begin
          if ((opcode_q == SQRT_OPCODE) && signs_out[0]) begin
            err_d   = ERR_SQRT_NEG;
            state_d = IDLE;
          end else if ((opcode_q == DIV_OPCODE) && div_zero) begin
            err_d   = ERR_DIV_ZERO;
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (ready_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers; status outputs are registered from next-state values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      err_q     <= ERR_NONE;
      idx_q     <= '0;
      last_q    <= '0;
      timer_q   <= '0;
      opcode_q  <= '0;
      start_q   <= 1'b0;
      load_q    <= 1'b0;
      start_out <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      opcode_q  <= opcode_d;
      start_q   <= start;
      load_q    <= load;
      start_out <= (state_d == ISSUE);
      busy      <= (state_d != IDLE);
      error     <= (err_d != ERR_NONE);
    end
  end

  // Operand slots; unwritten slots keep their previous contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operands_out <= '0;
      signs_out    <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
        if (mask_c[k]) begin
          operands_out[k*WORD_LENGTH +: WORD_LENGTH] <= conv_mag;
          signs_out[k]                               <= conv_sign;
        end
      end
    end
  end

endmodule
